// File: rtl/ela_pkg.sv
// ela_pkg: shared constants, FSM state encoding and address helper for the
// ELA deinterlacer controller.
//   IMG_W    pixels per row (power of two)
//   IN_ROWS  input field rows
//   AW       result memory address width
//   OUT_ROWS output frame rows (interleaved input + interpolated)
package ela_pkg;
    localparam int IMG_W    = 32;
    localparam int IN_ROWS  = 16;
    localparam int AW       = 10;
    localparam int OUT_ROWS = 2 * IN_ROWS - 1;
    localparam int CW       = $clog2(IMG_W);   // column index width
    localparam int RW       = $clog2(IN_ROWS); // input row index width
    localparam int ORW      = AW - CW;         // output row index width

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RECV,
        S_PRE,
        S_WR,
        S_RD_U,
        S_RD_L,
        S_DONE
    } ela_state_e;

    // Output rows are IMG_W-aligned, so the address is a plain concatenation.
    function automatic logic [AW-1:0] ela_addr(input logic [ORW-1:0] row,
                                               input logic [CW-1:0]  col);
        return {row, col};
    endfunction
endpackage

// File: rtl/ela_ctrl.sv
// ela_ctrl: sequencing controller for the ELA deinterlacer.
// Requests each input row, stores it on the even output line, then streams
// the two neighbouring lines through the ela_interp window and writes the
// interpolated odd line.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   req             one-cycle row request to the field source
//   in_data         input pixel stream
//   wen/addr        result memory write enable (1=write) and address
//   data_wr/data_rd result memory write / read data
//   dp_ld_u/dp_ld_l shift data_rd into the datapath upper / lower window
//   dp_edge         boundary column, datapath uses vertical average
//   dp_res          interpolated pixel from the datapath
//   done            frame complete, sticky until reset
module ela_ctrl
    import ela_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    output logic          req,
    input  logic [7:0]    in_data,
    output logic          wen,
    output logic [AW-1:0] addr,
    output logic [7:0]    data_wr,
    input  logic [7:0]    data_rd,
    output logic          dp_ld_u,
    output logic          dp_ld_l,
    output logic          dp_edge,
    input  logic [7:0]    dp_res,
    output logic          done
);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] R_LAST = RW'(IN_ROWS - 1);

    ela_state_e    state_q, state_d;
    logic [RW-1:0] r_q, r_d;
    logic [CW-1:0] c_q, c_d;

    logic [ORW-1:0] row_lo, row_mid, row_up, row_sel;
    logic [CW-1:0]  col_sel, fcol;

    // Read data goes straight to the datapath window; the controller only
    // sequences the strobes.
    logic unused_rd;
    assign unused_rd = ^data_rd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        req     = 1'b0;
        wen     = 1'b0;
        data_wr = '0;
        dp_ld_u = 1'b0;
        dp_ld_l = 1'b0;
        dp_edge = 1'b0;
        done    = 1'b0;
        row_sel = '0;
        col_sel = '0;

        row_lo  = {r_q, 1'b0};
        row_mid = row_lo - ORW'(1);
        row_up  = row_lo - ORW'(2);
        // Column fetched ahead of the write; clamping repeats the last column
        // so the window centre still lands on c for the final two columns.
        fcol    = (c_q >= CW'(IMG_W - 2)) ? C_LAST : c_q + CW'(2);

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                req     = 1'b1;
                c_d     = '0;
                state_d = S_RECV;
            end
            S_RECV: begin
                wen     = 1'b1;
                row_sel = row_lo;
                col_sel = c_q;
                data_wr = in_data;
                if (c_q == C_LAST) begin
                    c_d = '0;
                    if (r_q == '0) begin
                        // Row 0 has no line above it: nothing to interpolate yet.
                        r_d     = r_q + RW'(1);
                        state_d = S_REQ;
                    end else begin
                        state_d = S_PRE;
                    end
                end else begin
                    c_d = c_q + CW'(1);
                end
            end
            S_PRE: begin
                // c_q counts 0..3: bit0 picks upper/lower, bit1 the column.
                col_sel = {{(CW-1){1'b0}}, c_q[1]};
                if (!c_q[0]) begin
                    dp_ld_u = 1'b1;
                    row_sel = row_up;
                end else begin
                    dp_ld_l = 1'b1;
                    row_sel = row_lo;
                end
                if (c_q == CW'(3)) begin
                    c_d     = '0;
                    state_d = S_WR;
                end else begin
                    c_d = c_q + CW'(1);
                end
            end
            S_WR: begin
                wen     = 1'b1;
                row_sel = row_mid;
                col_sel = c_q;
                data_wr = dp_res;
                dp_edge = (c_q == '0) || (c_q == C_LAST);
                state_d = S_RD_U;
            end
            S_RD_U: begin
                dp_ld_u = 1'b1;
                row_sel = row_up;
                col_sel = fcol;
                state_d = S_RD_L;
            end
            S_RD_L: begin
                dp_ld_l = 1'b1;
                row_sel = row_lo;
                col_sel = fcol;
                // The last column keeps its trailing fetch pair so every
                // column costs exactly three cycles.
                if (c_q == C_LAST) begin
                    c_d = '0;
                    if (r_q == R_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        r_d     = r_q + RW'(1);
                        state_d = S_REQ;
                    end
                end else begin
                    c_d     = c_q + CW'(1);
                    state_d = S_WR;
                end
            end
            S_DONE: done = 1'b1;
            default: state_d = S_IDLE;
        endcase

        addr = (state_q == S_IDLE || state_q == S_REQ || state_q == S_DONE)
             ? '0 : ela_addr(row_sel, col_sel);
    end
endmodule

// File: tb/tb_ela_ctrl.sv
// tb_ela_ctrl: scoreboard bench for ela_ctrl. Expected memory writes and
// window reads are queued when each row request is served, and popped as the
// controller issues them. Memory model is combinational-read, write-on-edge.
module tb_ela_ctrl;
    import ela_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req, wen, dp_ld_u, dp_ld_l, dp_edge, done;
    logic [7:0]    in_data, data_wr, data_rd, dp_res;
    logic [AW-1:0] addr;
    logic [7:0]    mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    assign data_rd = mem[addr];
    assign dp_res  = 8'hA5;

    ela_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .in_data(in_data), .wen(wen),
        .addr(addr), .data_wr(data_wr), .data_rd(data_rd),
        .dp_ld_u(dp_ld_u), .dp_ld_l(dp_ld_l), .dp_edge(dp_edge),
        .dp_res(dp_res), .done(done)
    );

    typedef struct packed {logic [AW-1:0] a; logic [7:0] d; logic e;} wexp_t;
    typedef struct packed {logic [AW-1:0] a; logic up;} rexp_t;

    wexp_t wq[$];
    rexp_t rq[$];
    int    n_cmp = 0, n_bad = 0;
    int    cyc, nreq, src_row, src_start, n_distinct, last_wr, max_wr;
    bit    src_act, done_seen;
    bit    wr_seen [0:(1<<AW)-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] pat(input int n, input int k);
        return 8'((n * 32 + k) & 255);
    endfunction

    function automatic int exp_req(input int n);
        return (n == 0) ? 1 : 34 + 133 * (n - 1);
    endfunction

    function automatic logic [AW-1:0] ad(input int row, input int col);
        return AW'(row * 32 + col);
    endfunction

    task automatic push_row(input int n);
        int f;
        for (int k = 0; k < 32; k++) wq.push_back('{a: ad(2*n, k), d: pat(n, k), e: 1'b0});
        if (n > 0) begin
            rq.push_back('{a: ad(2*n-2, 0), up: 1'b1});
            rq.push_back('{a: ad(2*n,   0), up: 1'b0});
            rq.push_back('{a: ad(2*n-2, 1), up: 1'b1});
            rq.push_back('{a: ad(2*n,   1), up: 1'b0});
            for (int c = 0; c < 32; c++) begin
                wq.push_back('{a: ad(2*n-1, c), d: 8'hA5, e: (c == 0 || c == 31)});
                f = (c + 2 > 31) ? 31 : c + 2;
                rq.push_back('{a: ad(2*n-2, f), up: 1'b1});
                rq.push_back('{a: ad(2*n,   f), up: 1'b0});
            end
        end
    endtask

    // Entered and left at a falling edge; cyc is the cycle now in progress.
    task automatic step();
        wexp_t we;
        rexp_t re;
        if (src_act && cyc >= src_start && cyc < src_start + 32)
            in_data = pat(src_row, cyc - src_start);
        else
            in_data = 8'($urandom);
        #1;
        if (req) begin
            check("req_cyc", cyc, exp_req(nreq));
            if (nreq < IN_ROWS) push_row(nreq);
            src_row   = nreq;
            src_start = cyc + 1;
            src_act   = 1'b1;
            nreq++;
        end
        if (wen) begin
            if (wq.size() == 0) check("wr_unexpected", wq.size(), 1);
            else begin
                we = wq.pop_front();
                check("wr_addr", addr, we.a);
                check("wr_data", data_wr, we.d);
                check("wr_edge", dp_edge, we.e);
            end
            mem[addr] = data_wr;
            if (!wr_seen[addr]) n_distinct++;
            wr_seen[addr] = 1'b1;
            last_wr = int'(addr);
            if (int'(addr) > max_wr) max_wr = int'(addr);
        end else if (dp_ld_u || dp_ld_l) begin
            if (rq.size() == 0) check("rd_unexpected", rq.size(), 1);
            else begin
                re = rq.pop_front();
                check("rd_addr", addr, re.a);
                check("rd_strobe", {dp_ld_u, dp_ld_l}, re.up ? 2'b10 : 2'b01);
            end
        end
        if (done) begin
            if (!done_seen) check("done_cyc", cyc, 2029);
            done_seen = 1'b1;
        end else if (done_seen) begin
            check("done_sticky", done, 1);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic release_rst();
        wq.delete();
        rq.delete();
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = 8'h00;
            wr_seen[i] = 1'b0;
        end
        cyc = 0; nreq = 0; src_act = 1'b0; done_seen = 1'b0;
        n_distinct = 0; last_wr = -1; max_wr = -1;
        rst = 1'b1;
    endtask

    initial begin
        int exp_b;
        in_data = 8'h00;
        cyc = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_outs", {req, wen, addr, data_wr, dp_ld_u, dp_ld_l, dp_edge, done}, 0);

        // Partial run, then reset while receiving row 3 column 10.
        release_rst();
        while (cyc < 311) step();
        in_data = 8'h5C;
        #1;
        check("pre_rst_addr", addr, ad(6, 10));
        check("pre_rst_wen", wen, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_outs", {req, wen, addr, data_wr, dp_ld_u, dp_ld_l, dp_edge, done}, 0);
        repeat (2) @(negedge clk);

        // Full frame from a fresh release.
        release_rst();
        for (int i = 0; i < 2100 && !done_seen; i++) step();
        if (!done_seen) check("done_timeout", done_seen, 1);
        repeat (20) step();

        check("req_count", nreq, IN_ROWS);
        check("wq_left", wq.size(), 0);
        check("rq_left", rq.size(), 0);
        check("distinct_wr", n_distinct, 992);
        check("last_wr", last_wr, 959);
        check("max_wr", max_wr, 991);
        for (int row = 0; row < OUT_ROWS; row++)
            for (int col = 0; col < IMG_W; col++) begin
                exp_b = (row % 2 == 0) ? int'(pat(row / 2, col)) : 32'hA5;
                check((row % 2 == 0) ? "mem_even" : "mem_odd", mem[row * IMG_W + col], exp_b);
            end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
